// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: width codes, FSM states,
// size decode and lane masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] code);
        case (code)
            2'd0:    size_bytes = 4'd1;
            2'd1:    size_bytes = 4'd2;
            2'd2:    size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] code);
        case (code)
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, and the
// read-modify-write merge for partial stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] mask;

    assign shamt = {offset, 3'b000};
    assign lane  = word >> shamt;
    assign mask  = lane_mask(funct3[1:0]);

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            F3_D:    load_data = lane;
            F3_BU:   load_data = {56'b0, lane[7:0]};
            F3_HU:   load_data = {48'b0, lane[15:0]};
            F3_WU:   load_data = {32'b0, lane[31:0]};
            default: load_data = '0;
        endcase
    end

    assign merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a 64-bit-word memory; partial stores use RMW.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them.
module lsu_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_inv_addr,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        stall
);
    import lsu_pkg::*;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [2:0]  f3_q;
    logic [60:0] idx_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic        store_q;
    logic [4:0]  rd_q;
    logic [63:0] resp_data_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_err;
    logic        misalign_err;
    logic [2:0]  align_bits;
    logic [2:0]  req_off;
    logic [63:0] load_data;
    logic [63:0] merged;

    assign align_bits = 3'(size_bytes(req_funct3[1:0]) - 4'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_err = |(req_addr[2:0] & align_bits);
    assign req_off      = req_addr[2:0];
`else
    assign misalign_err = 1'b0;
    assign req_off      = req_addr[2:0] & ~align_bits;
`endif

    assign req_ready = (state == ST_IDLE) || (state == ST_RESP);
    assign accept    = req_ready && req_valid && (req_read || req_write);
    assign req_err   = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                       (req_read && req_write) || misalign_err;

    // Memory strobes decode straight from state so reset kills a pending write at once.
    assign mem_read   = (state == ST_RD);
    assign mem_write  = (state == ST_WR);
    assign mem_addr   = {3'b000, idx_q};
    assign mem_wdata  = (state == ST_WR) ? wdata_q : '0;
    assign resp_valid = (state == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign resp_rd    = rd_q;
    assign stall      = (req_valid && (req_read || req_write) && !req_ready) ||
                        (state == ST_RD) || (state == ST_WR);

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .word      (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (req_err)                    state_next = ST_RESP;
                    else if (req_read)              state_next = ST_RD;
                    else if (req_funct3[1:0] == 2'd3) state_next = ST_WR;
                    else                            state_next = ST_RD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt == 4'd1)
                    state_next = (store_q && !mem_inv_addr) ? ST_WR : ST_RESP;
            end
            ST_WR:   state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, sample memory on the last RD cycle and in WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            f3_q        <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            rd_q        <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (accept) begin
            cnt         <= 4'(MEM_LAT);
            f3_q        <= req_funct3;
            idx_q       <= req_addr[63:3];
            off_q       <= req_off;
            wdata_q     <= req_wdata;
            store_q     <= req_write;
            rd_q        <= req_rd;
            resp_data_q <= '0;
            resp_err_q  <= req_err;
        end else if (state == ST_RD) begin
            if (cnt == 4'd1) begin
                if (mem_inv_addr)  resp_err_q  <= 1'b1;
                else if (store_q)  wdata_q     <= merged;
                else               resp_data_q <= load_data;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (state == ST_WR) begin
            resp_err_q <= mem_inv_addr;
        end
    end

endmodule
